// File: rtl/updown_counter_param.sv
// updown_counter_param
//   Parametrised up/down counter: synchronous load (clamped to limit),
//   programmable step, runtime modulo limit, wrap or saturate at the range
//   ends, sticky overflow/underflow flags and a registered event pulse.
//
// Parameters
//   WIDTH    : counter/load/step/limit width (>= 2)
//   SATURATE : 0 = wrap at range ends, 1 = saturate at range ends
//
// Ports
//   clk        : clock, all state updates on posedge
//   rst_n      : asynchronous active-low reset
//   ld_en      : synchronous load of datain (priority over en)
//   en         : count enable
//   updwn      : direction, 1 = down, 0 = up
//   datain     : load value
//   step       : count magnitude
//   limit      : upper bound, legal range is 0..limit
//   flag_clr   : clears sticky ovf/unf (a coincident event wins)
//   dataout    : registered count
//   tc         : terminal count (combinational)
//   ovf        : sticky up-count crossed limit
//   unf        : sticky down-count crossed 0
//   wrap_pulse : one-cycle pulse per wrap/saturation event
module updown_counter_param #(
    parameter int unsigned WIDTH    = 8,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_en,
    input  logic             en,
    input  logic             updwn,
    input  logic [WIDTH-1:0] datain,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] dataout,
    output logic             tc,
    output logic             ovf,
    output logic             unf,
    output logic             wrap_pulse
);

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic             r_unf;
    logic             r_wrap;

    logic [WIDTH-1:0] w_se;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_lim_p1;
    logic [WIDTH-1:0] w_up_wrap;
    logic [WIDTH-1:0] w_dn_wrap;
    logic [WIDTH-1:0] w_next;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic             w_event;

    assign w_se     = (step < limit) ? step : limit;
    assign w_load   = (datain < limit) ? datain : limit;
    assign w_sum    = {1'b0, r_count} + {1'b0, w_se};
    // limit+1 needs the extra bit so a full-range limit gives modulo 2^WIDTH
    assign w_lim_p1 = {1'b0, limit} + (WIDTH+1)'(1);
    // Both wrap results are < limit+1 by construction, so truncation is exact
    assign w_up_wrap = WIDTH'(w_sum - w_lim_p1);
    assign w_dn_wrap = WIDTH'({1'b0, r_count} + w_lim_p1 - {1'b0, w_se});

    always_comb begin
        w_next    = r_count;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        w_event   = 1'b0;
        if (ld_en) begin
            w_next = w_load;
        end else if (en) begin
            if (r_count > limit) begin
                // limit was lowered below the current count
                w_next    = limit;
                w_ovf_set = 1'b1;
                w_event   = 1'b1;
            end else if (w_se != '0) begin
                if (!updwn) begin
                    if (w_sum > {1'b0, limit}) begin
                        w_ovf_set = 1'b1;
                        w_event   = 1'b1;
                        w_next    = SATURATE ? limit : w_up_wrap;
                    end else begin
                        w_next = w_sum[WIDTH-1:0];
                    end
                end else begin
                    if (r_count >= w_se) begin
                        w_next = r_count - w_se;
                    end else begin
                        w_unf_set = 1'b1;
                        w_event   = 1'b1;
                        w_next    = SATURATE ? '0 : w_dn_wrap;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next;
            // set has priority over a coincident clear
            r_ovf   <= w_ovf_set | (r_ovf & ~flag_clr);
            r_unf   <= w_unf_set | (r_unf & ~flag_clr);
            r_wrap  <= w_event;
        end
    end

    assign dataout    = r_count;
    assign tc         = updwn ? (r_count == '0) : (r_count == limit);
    assign ovf        = r_ovf;
    assign unf        = r_unf;
    assign wrap_pulse = r_wrap;

endmodule

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised up/down counter with synchronous load, programmable step, runtime modulo limit, and selectable wrap or saturate behaviour at the range ends. It adds terminal-count, sticky overflow/underflow and wrap-event outputs that the single-width 8-bit counter does not have. It is the next-generation counter datapath for the counter assertion test environment: the property checkers bind to its `dataout`, and it serves as a reusable timer/event counter elsewhere.

## Interface
- `WIDTH`, default 8: counter, load, step and limit width (≥2).
- `SATURATE`, default 0: 0 = wrap at range ends, 1 = saturate at range ends.
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst_n`  in  1  reset; **one clock; reset is asynchronous and active-low**.
- `ld_en`  in  1  synchronous load of `datain`.
- `en`  in  1  count enable.
- `updwn`  in  1  direction: 1 = down, 0 = up.
- `datain`  in  WIDTH  load value.
- `step`  in  WIDTH  count increment/decrement magnitude.
- `limit`  in  WIDTH  upper bound; legal count range is 0..`limit`.
- `flag_clr`  in  1  clears the sticky `ovf` and `unf` flags.
- `dataout`  out  WIDTH  registered count.
- `tc`  out  1  terminal count, combinational.
- `ovf`  out  1  sticky: an up-count crossed `limit`.
- `unf`  out  1  sticky: a down-count crossed 0.
- `wrap_pulse`  out  1  registered one-cycle pulse marking a wrap or saturation event.

## Operation
- Priority at each posedge: `rst_n` low, then `ld_en`, then `en`, otherwise hold.
- **Load:**
  - `dataout` ← min(`datain`, `limit`).
  - Flags are unaffected and `wrap_pulse` is 0.
- **Effective step:**
  - Se = min(`step`, `limit`).
  - Se = 0 means the counter holds with no event, even when `en`=1.
- **Out-of-range:** if `en` is active and `dataout` > `limit` (because `limit` was lowered at runtime):
  - `dataout` ← `limit`, `ovf` ← 1, `wrap_pulse` ← 1.
  - This applies to both directions and both modes.
- **Up count** (`updwn`=0): compute S = `dataout` + Se in WIDTH+1 bits.
  - S ≤ `limit`: `dataout` ← S.
  - S > `limit`: event. `ovf` ← 1, `wrap_pulse` ← 1, and `dataout` ← S − (`limit`+1) when SATURATE=0, or `limit` when SATURATE=1.
- **Down count** (`updwn`=1):
  - `dataout` ≥ Se: `dataout` ← `dataout` − Se.
  - Otherwise: event. `unf` ← 1, `wrap_pulse` ← 1, and `dataout` ← `dataout` + (`limit`+1) − Se when SATURATE=0 (computed in WIDTH+1 bits), or 0 when SATURATE=1.
- **Saturate mode at a bound:** counting further outward while already at 0 or `limit` still counts as an event and re-asserts `wrap_pulse` every enabled cycle.
- **tc:**
  - = (`updwn`=0 and `dataout`==`limit`) or (`updwn`=1 and `dataout`==0).
  - Independent of `en`.
- **flag_clr:**
  - Clears `ovf`/`unf` at the next posedge.
  - If an event of the same kind occurs on that edge, set wins and the flag stays 1.
- **Limit cases:**
  - `limit`=0 forces the range to {0}. Se=0, so the counter holds at 0.
  - `limit` = 2^WIDTH−1 gives a full-range modulo-2^WIDTH counter.

## Timing
- Reset values:
  - `dataout`=0, `ovf`=0, `unf`=0, `wrap_pulse`=0.
  - `tc` follows its equation, so it is 1 during reset iff `updwn`=1.
- Reset assertion clears all registers immediately, with no clock needed. Deassertion takes effect at the first posedge after release.
- Reset mid-count aborts the operation. There is no pending state.
- Latency:
  - Load, count, and flag set/clear are visible one cycle after the sampling edge.
  - `wrap_pulse` is high in the same cycle as the post-event `dataout`, for exactly one cycle per event edge.
- `tc` has zero latency from `dataout`, `updwn` and `limit`.
- Inputs are sampled only at posedge. `limit` and `step` may change at any cycle.

## Test plan
- **Reset:** count to 0x37, pulse `rst_n` low between edges -> `dataout`=0, `ovf`=`unf`=`wrap_pulse`=0 immediately. With `updwn`=1, `tc`=1.
- **Load clamp:** `limit`=100, `datain`=200, `ld_en`=1 with `en`=1 -> `dataout`=100 next cycle. Load wins over count; no flags.
- **Wrap up:** SATURATE=0, WIDTH=8, `limit`=9, `step`=3, start 0, count up 4 edges -> 3, 6, 9, 2. `ovf`=1 and `wrap_pulse` high only with 2. `tc`=1 while at 9.
- **Saturate down:** SATURATE=1, `limit`=255, load 5, `step`=4, `updwn`=1 -> 1, 0, 0. `unf`=1. `wrap_pulse` high on the edges producing the two 0s.
- **Sticky/clear race:** `ovf` set; `flag_clr`=1 on an edge with no event -> `ovf`=0. Repeat with a coincident overflow -> `ovf` stays 1.
- **Runtime limit drop:** count at 50, `limit` changed to 20, `en`=1 -> `dataout`=20, `ovf`=1, `wrap_pulse`=1. `step`=0 with `en`=1 -> hold, no event.
